// File: rtl/denise_pkg.sv
// Shared constants for the Denise collision detector: register addresses,
// CLXDAT hit bit positions and CLXCON/CLXCON2 field offsets.
package denise_pkg;

  // Full 9-bit register addresses; the bus carries bits [8:1].
  localparam logic [8:0] CLXDAT_ADR_DEF  = 9'h00E;
  localparam logic [8:0] CLXCON_ADR_DEF  = 9'h098;
  localparam logic [8:0] CLXCON2_ADR_DEF = 9'h10E;

  // CLXCON fields
  localparam int CLXCON_MVBP_LSB  = 0;   // MVBP6..1 at [5:0]
  localparam int CLXCON_ENBP_LSB  = 6;   // ENBP6..1 at [11:6]
  localparam int CLXCON_ENSP_LSB  = 12;  // ENSP7,5,3,1 at [15:12]

  // CLXCON2 fields (AGA planes 7/8)
  localparam int CLXCON2_MVBP_LSB = 0;   // MVBP8,7 at [1:0]
  localparam int CLXCON2_ENBP_LSB = 6;   // ENBP8,7 at [7:6]

  // CLXDAT hit bit positions
  localparam int CLX_EVEN_ODD = 0;
  localparam int CLX_ODD_G0   = 1;       // odd & g0..g3 at 1..4
  localparam int CLX_EVEN_G0  = 5;       // even & g0..g3 at 5..8
  localparam int CLX_G0_G1    = 9;
  localparam int CLX_G0_G2    = 10;
  localparam int CLX_G0_G3    = 11;
  localparam int CLX_G1_G2    = 12;
  localparam int CLX_G1_G3    = 13;
  localparam int CLX_G2_G3    = 14;

endpackage

// File: rtl/denise_collision_match.sv
// Combinational collision match: per-plane compare, odd/even playfield
// terms, sprite group terms, and the 15-bit hit vector gated by clxena.
module denise_collision_match
  import denise_pkg::*;
(
  input  logic [7:0]  bpldata,
  input  logic [7:0]  nsprite,
  input  logic [15:0] clxcon,
  input  logic [15:0] clxcon2,
  input  logic        clxena,
  output logic [14:0] hits
);

  logic [7:0] enbp, mvbp, p;
  logic [3:0] ensp, g;
  logic       odd, even;
  logic       unused_clxcon2;

  // Plane 8..1 enable/match-value vectors assembled from both registers
  assign enbp = {clxcon2[CLXCON2_ENBP_LSB +: 2], clxcon[CLXCON_ENBP_LSB +: 6]};
  assign mvbp = {clxcon2[CLXCON2_MVBP_LSB +: 2], clxcon[CLXCON_MVBP_LSB +: 6]};
  assign ensp = clxcon[CLXCON_ENSP_LSB +: 4];

  // Remaining CLXCON2 bits are storage only
  assign unused_clxcon2 = ^{clxcon2[15:8], clxcon2[5:2]};

  // A disabled plane always matches
  assign p    = ~enbp | ~(bpldata ^ mvbp);
  assign odd  = p[0] & p[2] & p[4] & p[6];
  assign even = p[1] & p[3] & p[5] & p[7];

  // Even sprite always counts; odd partner only when its ENSP bit is set
  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign g[k] = nsprite[2*k] | (ensp[k] & nsprite[2*k+1]);
  end

  // Hit vector assembly, all terms qualified by the sensing window
  always_comb begin
    hits = '0;
    hits[CLX_EVEN_ODD] = even & odd;
    for (int k = 0; k < 4; k++) begin
      hits[CLX_ODD_G0 + k]  = odd  & g[k];
      hits[CLX_EVEN_G0 + k] = even & g[k];
    end
    hits[CLX_G0_G1] = g[0] & g[1];
    hits[CLX_G0_G2] = g[0] & g[2];
    hits[CLX_G0_G3] = g[0] & g[3];
    hits[CLX_G1_G2] = g[1] & g[2];
    hits[CLX_G1_G3] = g[1] & g[3];
    hits[CLX_G2_G3] = g[2] & g[3];
    hits = hits & {15{clxena}};
  end

endmodule

// File: rtl/denise_collision.sv
// Denise collision detector: CLXCON/CLXCON2 control registers and the
// sticky, clear-on-read CLXDAT register driven onto the read bus.
// Optional build macro DENISE_COLLISION_PIPE_EN registers the pixel inputs
// on clk7_en ahead of the match logic (one extra enable of latency).
module denise_collision
  import denise_pkg::*;
#(
  parameter logic [8:0] CLXDAT_ADR  = CLXDAT_ADR_DEF,
  parameter logic [8:0] CLXCON_ADR  = CLXCON_ADR_DEF,
  parameter logic [8:0] CLXCON2_ADR = CLXCON2_ADR_DEF
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        clk7_en,
  input  logic        aga,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [8:1]  bpldata,
  input  logic [7:0]  nsprite,
  input  logic        clxena,
  output logic [15:0] data_out
);

  logic [15:0] clxcon, clxcon2;
  logic [14:0] clxdat, hits;
  logic        rd, rd_prev, clr;
  logic [7:0]  bpl_m, nspr_m;
  logic        ena_m;

`ifdef DENISE_COLLISION_PIPE_EN
  // Register pixel inputs to break the path from sprite priority logic
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      bpl_m  <= '0;
      nspr_m <= '0;
      ena_m  <= 1'b0;
    end else if (clk7_en) begin
      bpl_m  <= bpldata;
      nspr_m <= nsprite;
      ena_m  <= clxena;
    end
  end
`else
  assign bpl_m  = bpldata;
  assign nspr_m = nsprite;
  assign ena_m  = clxena;
`endif

  denise_collision_match u_match (
    .bpldata (bpl_m),
    .nsprite (nspr_m),
    .clxcon  (clxcon),
    .clxcon2 (clxcon2),
    .clxena  (ena_m),
    .hits    (hits)
  );

  assign rd  = (reg_address_in == CLXDAT_ADR[8:1]);
  assign clr = clk7_en & rd & ~rd_prev;

  // Control register writes; a CLXCON write always wipes CLXCON2
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      clxcon  <= '0;
      clxcon2 <= '0;
    end else if (clk7_en) begin
      if (reg_address_in == CLXCON_ADR[8:1]) begin
        clxcon  <= data_in;
        clxcon2 <= '0;
      end else if (reg_address_in == CLXCON2_ADR[8:1] && aga) begin
        clxcon2 <= data_in;
      end
    end
  end

  // Sticky accumulation with one clear per read access; same-cycle hits survive
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      clxdat  <= '0;
      rd_prev <= 1'b0;
    end else if (clk7_en) begin
      clxdat  <= (clr ? 15'h0000 : clxdat) | hits;
      rd_prev <= rd;
    end
  end

  assign data_out = rd ? {1'b1, clxdat} : 16'h0000;

endmodule

// File: tb/tb_denise_collision.sv
// Randomized scoreboard bench for denise_collision against a behavioural
// model of the collision rules.
module tb_denise_collision;

  localparam logic [7:0] A_DAT  = 8'h07;   // 0x00E >> 1
  localparam logic [7:0] A_CON  = 8'h4C;   // 0x098 >> 1
  localparam logic [7:0] A_CON2 = 8'h87;   // 0x10E >> 1
  localparam logic [7:0] A_OTH  = 8'hA0;   // 0x140 >> 1

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk7_en = 1'b0;
  logic        aga = 1'b0;
  logic [7:0]  addr = A_OTH;
  logic [15:0] data_in = '0;
  logic [7:0]  bpldata = '0;
  logic [7:0]  nsprite = '0;
  logic        clxena = 1'b0;
  logic [15:0] data_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  string       name_q[$];

  // Reference model state
  logic [15:0] m_con, m_con2;
  logic [14:0] m_dat;
  logic        m_rdprev;
  logic [7:0]  m_bpl_q, m_nspr_q;
  logic        m_ena_q;

  denise_collision dut (
    .clk            (clk),
    ._reset         (rst_n),
    .clk7_en        (clk7_en),
    .aga            (aga),
    .reg_address_in (addr),
    .data_in        (data_in),
    .bpldata        (bpldata),
    .nsprite        (nsprite),
    .clxena         (clxena),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  // Collision rules, written from the register description
  function automatic logic [14:0] ref_hits(input logic [7:0] bpl, input logic [7:0] ns,
                                           input logic ena, input logic [15:0] con,
                                           input logic [15:0] con2);
    logic [14:0] h;
    bit pm [1:8];
    bit grp [0:3];
    bit odd, even;
    int idx;
    h = '0;
    for (int i = 1; i <= 8; i++) begin
      bit en, mv;
      if (i <= 6) begin en = con[5 + i]; mv = con[i - 1]; end
      else        begin en = con2[i - 1]; mv = con2[i - 7]; end
      pm[i] = !en || (bpl[i-1] == mv);
    end
    odd  = pm[1] && pm[3] && pm[5] && pm[7];
    even = pm[2] && pm[4] && pm[6] && pm[8];
    for (int k = 0; k < 4; k++)
      grp[k] = ns[2*k] || (con[12 + k] && ns[2*k+1]);
    h[0] = even && odd;
    for (int k = 0; k < 4; k++) begin
      h[1 + k] = odd && grp[k];
      h[5 + k] = even && grp[k];
    end
    idx = 9;
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++) begin
        h[idx] = grp[a] && grp[b];
        idx++;
      end
    return ena ? h : 15'h0;
  endfunction

  task automatic model_reset();
    m_con = '0; m_con2 = '0; m_dat = '0; m_rdprev = 1'b0;
    m_bpl_q = '0; m_nspr_q = '0; m_ena_q = 1'b0;
  endtask

  // Advance the model by one enabled tick using the inputs just sampled
  task automatic model_step(input logic [7:0] a, input logic [15:0] d, input logic ag,
                            input logic [7:0] bpl, input logic [7:0] ns, input logic ena);
    logic [14:0] h;
    bit rd;
`ifdef DENISE_COLLISION_PIPE_EN
    h = ref_hits(m_bpl_q, m_nspr_q, m_ena_q, m_con, m_con2);
`else
    h = ref_hits(bpl, ns, ena, m_con, m_con2);
`endif
    rd = (a == A_DAT);
    m_dat = ((rd && !m_rdprev) ? 15'h0 : m_dat) | h;
    m_rdprev = rd;
    if (a == A_CON) begin m_con = d; m_con2 = '0; end
    else if (a == A_CON2 && ag) m_con2 = d;
    m_bpl_q = bpl; m_nspr_q = ns; m_ena_q = ena;
  endtask

  // One 28 MHz cycle: drive, push expected bus value, clock, update model
  task automatic cyc(input string nm, input logic [7:0] a, input logic [15:0] d,
                     input logic en, input logic ag, input logic [7:0] bpl,
                     input logic [7:0] ns, input logic ena);
    addr = a; data_in = d; clk7_en = en; aga = ag;
    bpldata = bpl; nsprite = ns; clxena = ena;
    exp_q.push_back((a == A_DAT) ? {1'b1, m_dat} : 16'h0000);
    name_q.push_back(nm);
    @(posedge clk);
    if (en) model_step(a, d, ag, bpl, ns, ena);
    #1;
  endtask

  // Monitor: compare the bus value presented each cycle against the scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (data_out !== e) begin
        n_bad++;
        $display("FAIL %s: data_out=%h expected=%h", nm, data_out, e);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state reads
    cyc("rst_rd", A_DAT, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("rst_oth", A_OTH, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Sprites 0 and 2 with all planes matching
    cyc("con0", A_CON, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("spr02", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h05, 1'b1);
    cyc("spr02_rd", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("spr02_rd2", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Plane 1 match enabled
    cyc("con41", A_CON, 16'h0041, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("p1_hit", A_OTH, 16'h0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1);
    cyc("p1_rd", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("p1_miss", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b1);
    cyc("p1m_rd", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Held read with continuing hits: one clear, same-cycle hit retained
    cyc("pre_hit", A_OTH, 16'h0, 1'b1, 1'b0, 8'h01, 8'h11, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("hold_rd", A_DAT, 16'h0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b1);
    cyc("hold_gap", A_OTH, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("hold_rd2", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // AGA CLXCON2, then wiped by a CLXCON write; non-AGA write ignored
    cyc("con2_w", A_CON2, 16'h0080, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    cyc("aga_hit", A_OTH, 16'h0, 1'b1, 1'b1, 8'h80, 8'h01, 1'b1);
    cyc("aga_rd", A_DAT, 16'h0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    cyc("con_wipe", A_CON, 16'h0000, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    cyc("wipe_hit", A_OTH, 16'h0, 1'b1, 1'b1, 8'h80, 8'h01, 1'b1);
    cyc("wipe_rd", A_DAT, 16'h0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("con2_noaga", A_CON2, 16'h0080, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("noaga_hit", A_OTH, 16'h0, 1'b1, 1'b0, 8'h80, 8'h01, 1'b1);
    cyc("noaga_rd", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] a;
      r = $urandom_range(0, 15);
      a = (r < 5) ? A_DAT : (r == 5) ? A_CON : (r == 6) ? A_CON2 :
          (r == 7) ? 8'($urandom) : A_OTH;
      cyc("rand", a, 16'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
          8'($urandom), 8'($urandom) & 8'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Saturate CLXDAT, then assert reset between clock edges
    cyc("sat_con", A_CON, 16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("sat", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1);
    cyc("sat_rd", A_DAT, 16'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    addr = A_DAT; clk7_en = 1'b0; nsprite = 8'h00; clxena = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    exp_q.push_back({1'b1, m_dat});
    name_q.push_back("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("post_rst_rd", A_DAT, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc("idle", A_OTH, 16'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
